// File: rtl/tpu_pkg.sv
// Shared TPU types: data word, activation encodings, activation-stage instruction and FSM state.
package tpu_pkg;

   localparam int unsigned BYTE_WIDTH = 8;
   typedef logic [BYTE_WIDTH-1:0] word_type;

   typedef enum logic [1:0] {
      NO_ACTIVATION = 2'd0,
      RELU          = 2'd1,
      SIGMOID       = 2'd2
   } activation_type;

   // Enable-high latency of the activation unit, data_in to data_out.
   localparam int unsigned ACT_PIPE_LATENCY = 3;

   localparam int unsigned ACT_ACC_ADDR_WIDTH = 9;
   localparam int unsigned ACT_BUF_ADDR_WIDTH = 24;
   localparam int unsigned ACT_LENGTH_WIDTH   = 32;

   typedef struct packed {
      logic [ACT_ACC_ADDR_WIDTH-1:0] acc_addr;
      logic [ACT_BUF_ADDR_WIDTH-1:0] buf_addr;
      logic [ACT_LENGTH_WIDTH-1:0]   length;
      activation_type                func;
      logic                          is_signed;
   } activation_instr_type;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } act_ctrl_state_type;

   // Map any encoding outside the defined set onto the pass-through function.
   function automatic activation_type sanitize_act(input activation_type f);
      case (f)
         RELU, SIGMOID: return f;
         default:       return NO_ACTIVATION;
      endcase
   endfunction

endpackage

// File: rtl/act_align_pipe.sv
// Valid/address delay line of DEPTH stages with async active-low clear.
// Ports: i_valid/i_addr enter stage 0; o_valid_taps exposes every stage's
// valid (bit DEPTH-1 is the output); o_addr is the address leaving the line.
module act_align_pipe #(
   parameter int unsigned DEPTH      = 5,
   parameter int unsigned ADDR_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DEPTH-1:0]      o_valid_taps,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   logic [DEPTH-1:0]      r_valid;
   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];

   // Shift valid and address one stage per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_addr[i] <= '0;
      end else begin
         r_valid   <= {r_valid[DEPTH-2:0], i_valid};
         r_addr[0] <= i_addr;
         for (int i = 1; i < int'(DEPTH); i++) r_addr[i] <= r_addr[i-1];
      end
   end

   assign o_valid_taps = r_valid;
   assign o_addr       = r_addr[DEPTH-1];

endmodule

// File: rtl/activation_control.sv
// Activation-stage sequencer: accepts one instruction, streams accumulator
// row reads, keeps function/signedness aligned with the activation unit's
// data_in, and issues unified-buffer writes after the fixed pipe latency.
// Ports: instr_* handshake/fields in; acc_read_* to accumulator;
// act_* to activation unit; buf_write_* to unified buffer; busy/done status.
module activation_control
   import tpu_pkg::*;
#(
   parameter int unsigned ACC_ADDR_WIDTH   = ACT_ACC_ADDR_WIDTH,
   parameter int unsigned BUF_ADDR_WIDTH   = ACT_BUF_ADDR_WIDTH,
   parameter int unsigned LENGTH_WIDTH     = ACT_LENGTH_WIDTH,
   parameter int unsigned ACC_READ_LATENCY = 2,
   parameter int unsigned ACT_LATENCY      = ACT_PIPE_LATENCY
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
   input  logic [BUF_ADDR_WIDTH-1:0] instr_buf_addr,
   input  logic [LENGTH_WIDTH-1:0]   instr_length,
   input  activation_type            instr_function,
   input  logic                      instr_signed,
   output logic                      acc_read_en,
   output logic [ACC_ADDR_WIDTH-1:0] acc_read_addr,
   output logic                      act_enable,
   output activation_type            act_function,
   output logic                      act_signed,
   output logic                      buf_write_en,
   output logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned PIPE_DEPTH = ACC_READ_LATENCY + ACT_LATENCY;

   act_ctrl_state_type        r_state, w_state_nxt;
   logic [LENGTH_WIDTH-1:0]   r_remaining, w_remaining_nxt;
   logic [BUF_ADDR_WIDTH-1:0] r_issue_buf, w_issue_buf_nxt;
   logic [ACC_ADDR_WIDTH-1:0] r_acc_read_addr, w_rd_addr_nxt;
   logic                      r_acc_read_en, w_rd_en_nxt;
   logic                      r_done, w_done_nxt;
   logic                      w_latch;
   logic                      r_instr_ready, r_busy, r_act_signed;
   logic                      r_lat_signed;
   activation_type            r_lat_function, r_act_function;
   logic [PIPE_DEPTH-1:0]     w_taps;
   logic [BUF_ADDR_WIDTH-1:0] w_pipe_addr;
   logic                      w_fn_load;
   logic                      w_last_write;

   act_align_pipe #(
      .DEPTH      (PIPE_DEPTH),
      .ADDR_WIDTH (BUF_ADDR_WIDTH)
   ) u_align (
      .clk          (clk),
      .rst_n        (rst),
      .i_valid      (r_acc_read_en),
      .i_addr       (r_issue_buf),
      .o_valid_taps (w_taps),
      .o_addr       (w_pipe_addr)
   );

   // Load function/signedness one cycle before a row reaches the activation unit.
   generate
      if (ACC_READ_LATENCY >= 2) begin : g_fn_tap
         assign w_fn_load = w_taps[ACC_READ_LATENCY-2];
      end else begin : g_fn_direct
         assign w_fn_load = r_acc_read_en;
      end
   endgenerate

   // Last write: output stage valid with nothing behind it.
   assign w_last_write = w_taps[PIPE_DEPTH-1] && (w_taps[PIPE_DEPTH-2:0] == '0);

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_rd_en_nxt     = 1'b0;
      w_rd_addr_nxt   = r_acc_read_addr;
      w_issue_buf_nxt = r_issue_buf;
      w_remaining_nxt = r_remaining;
      w_done_nxt      = 1'b0;
      w_latch         = 1'b0;
      case (r_state)
         IDLE: begin
            if (instr_valid) begin
               w_latch = 1'b1;
               if (instr_length != '0) begin
                  w_state_nxt     = READ;
                  w_rd_en_nxt     = 1'b1;
                  w_rd_addr_nxt   = instr_acc_addr;
                  w_issue_buf_nxt = instr_buf_addr;
                  w_remaining_nxt = instr_length - LENGTH_WIDTH'(1);
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         READ: begin
            if (r_remaining != '0) begin
               w_rd_en_nxt     = 1'b1;
               w_rd_addr_nxt   = r_acc_read_addr + ACC_ADDR_WIDTH'(1);
               w_issue_buf_nxt = r_issue_buf + BUF_ADDR_WIDTH'(1);
               w_remaining_nxt = r_remaining - LENGTH_WIDTH'(1);
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_last_write) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= IDLE;
         r_remaining     <= '0;
         r_issue_buf     <= '0;
         r_acc_read_addr <= '0;
         r_acc_read_en   <= 1'b0;
         r_done          <= 1'b0;
         r_instr_ready   <= 1'b1;
         r_busy          <= 1'b0;
         r_lat_function  <= NO_ACTIVATION;
         r_lat_signed    <= 1'b0;
         r_act_function  <= NO_ACTIVATION;
         r_act_signed    <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_remaining     <= w_remaining_nxt;
         r_issue_buf     <= w_issue_buf_nxt;
         r_acc_read_addr <= w_rd_addr_nxt;
         r_acc_read_en   <= w_rd_en_nxt;
         r_done          <= w_done_nxt;
         r_instr_ready   <= (w_state_nxt == IDLE);
         r_busy          <= (w_state_nxt != IDLE);
         if (w_latch) begin
            r_lat_function <= sanitize_act(instr_function);
            r_lat_signed   <= instr_signed;
         end
         if (w_fn_load) begin
            r_act_function <= r_lat_function;
            r_act_signed   <= r_lat_signed;
         end
      end
   end

   assign instr_ready    = r_instr_ready;
   assign acc_read_en    = r_acc_read_en;
   assign acc_read_addr  = r_acc_read_addr;
   assign act_enable     = r_busy;
   assign act_function   = r_act_function;
   assign act_signed     = r_act_signed;
   assign buf_write_en   = w_taps[PIPE_DEPTH-1];
   assign buf_write_addr = w_pipe_addr;
   assign busy           = r_busy;
   assign done           = r_done;

endmodule
